usb_rx_bit_decoder: RTL and testbench

Upstream neighbour of the RX serial-to-parallel shift register in the USB full-speed receive path. It takes already-synchronized D+/D- samples and recovers bit timing with a resynchronizing oversample counter. It NRZI-decodes each sampled bit, strips stuffed bits, and detects EOP. Its outputs are a one-cycle shift_enable strobe plus a serial data bit, which directly drive the shift register's shift_enable and serial_in.

---
 rtl/usb_rx_pkg.sv | 8 +
 rtl/usb_rx_bit_decoder_if.sv | 13 +
 rtl/usb_edge_detect.sv | 15 +
 rtl/usb_rx_bit_decoder.sv | 115 +++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding, line-state codes and defaults for the USB RX bit decoder.
package usb_rx_pkg;
    typedef enum logic [1:0] {IDLE, RCV, SE0_1, SE0_2} rx_bit_state_t;
    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam int DEF_CLKS_PER_BIT = 8;
endpackage

// File: rtl/usb_rx_bit_decoder_if.sv
// usb_rx_bit_decoder_if: line inputs and decoded-bit outputs of the USB RX bit decoder.
interface usb_rx_bit_decoder_if;
    logic dp_in;
    logic dm_in;
    logic rcv_en;
    logic shift_enable;
    logic serial_out;
    logic eop;
    logic stuff_err;
    logic active;
    modport master (output dp_in, dm_in, rcv_en, input shift_enable, serial_out, eop, stuff_err, active);
    modport slave (input dp_in, dm_in, rcv_en, output shift_enable, serial_out, eop, stuff_err, active);
endinterface

// File: rtl/usb_edge_detect.sv
// usb_edge_detect: flags a D+ transition against its registered copy, ignoring SE0 entry.
module usb_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic dp,
    input  logic dm,
    output logic edge_seen
);
    logic dp_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dp_q <= 1'b1;
        else dp_q <= dp;
    end
    assign edge_seen = (dp != dp_q) && (dp || dm);
endmodule

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: oversampled bit recovery, NRZI decode, bit-unstuffing and EOP detection.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_PT = 3,
    parameter int MAX_ONES = 6
) (
    input logic clk,
    input logic rst,
    usb_rx_bit_decoder_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(MAX_ONES + 1);
    rx_bit_state_t state;
    logic [CW-1:0] counter, cnt_eff;
    logic [OW-1:0] ones;
    logic prev_dp, edge_seen, sample, dbit;
    logic [1:0] line, last_line, sline;
    usb_edge_detect u_edge (
        .clk(clk),
        .rst(rst),
        .dp(bus.dp_in),
        .dm(bus.dm_in),
        .edge_seen(edge_seen)
    );
    assign line = {bus.dp_in, bus.dm_in};
    // dp1/dm1 is not a legal line state, so reuse whatever was last sampled
    assign sline = (line == 2'b11) ? last_line : line;
    assign cnt_eff = edge_seen ? '0 : counter;
    assign sample = (state != IDLE) && (cnt_eff == CW'(SAMPLE_PT));
    assign dbit = (sline[1] == prev_dp);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            counter <= '0;
            ones <= '0;
            prev_dp <= 1'b1;
            last_line <= J;
            bus.shift_enable <= 1'b0;
            bus.serial_out <= 1'b0;
            bus.eop <= 1'b0;
            bus.stuff_err <= 1'b0;
            bus.active <= 1'b0;
        end else begin
            bus.shift_enable <= 1'b0;
            bus.eop <= 1'b0;
            bus.stuff_err <= 1'b0;
            if (!bus.rcv_en) begin
                state <= IDLE;
                counter <= '0;
                ones <= '0;
                prev_dp <= 1'b1;
                last_line <= J;
                bus.active <= 1'b0;
            end else if (state == IDLE) begin
                if (edge_seen) begin
                    state <= RCV;
                    counter <= CW'(1);
                    ones <= '0;
                    prev_dp <= 1'b1;
                    last_line <= J;
                    bus.active <= 1'b1;
                end
            end else begin
                counter <= (cnt_eff == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_eff + CW'(1);
                if (sample) begin
                    last_line <= sline;
                    case (state)
                        RCV: begin
                            if (sline == SE0) state <= SE0_1;
                            else begin
                                prev_dp <= sline[1];
                                if (ones == OW'(MAX_ONES)) begin
                                    ones <= '0;
                                    if (dbit) begin
                                        bus.stuff_err <= 1'b1;
                                        bus.active <= 1'b0;
                                        state <= IDLE;
                                        counter <= '0;
                                    end
                                end else begin
                                    bus.shift_enable <= 1'b1;
                                    bus.serial_out <= dbit;
                                    ones <= dbit ? ones + OW'(1) : '0;
                                end
                            end
                        end
                        SE0_1: begin
                            if (sline == SE0) state <= SE0_2;
                            else begin
                                bus.stuff_err <= 1'b1;
                                bus.active <= 1'b0;
                                state <= IDLE;
                                counter <= '0;
                                ones <= '0;
                            end
                        end
                        default: begin
                            // long SE0 simply stays here until J or K arrives
                            if (sline != SE0) begin
                                bus.eop <= (sline == J);
                                bus.stuff_err <= (sline != J);
                                bus.active <= 1'b0;
                                state <= IDLE;
                                counter <= '0;
                                ones <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb_usb_rx_bit_decoder: directed line waveforms with hand-computed decoded bits and pulse counts.
module tb_usb_rx_bit_decoder;
    import usb_rx_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int nstb, neop, nerr, nmulti, first_cyc, edge_cyc;
    logic err_active;
    logic [31:0] bits;
    usb_rx_bit_decoder_if bus ();
    usb_rx_bit_decoder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.shift_enable) begin
            if (nstb == 0) first_cyc = cyc;
            bits = {bits[30:0], bus.serial_out};
            nstb++;
        end
        if (bus.eop) neop++;
        if (bus.stuff_err) begin
            nerr++;
            err_active = bus.active;
        end
        if ((bus.shift_enable & bus.eop) | (bus.shift_enable & bus.stuff_err) | (bus.eop & bus.stuff_err)) nmulti++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        nstb = 0; neop = 0; nerr = 0; bits = '0; first_cyc = -1; err_active = 1'bx;
    endtask
    task automatic put(input logic [1:0] l, input int n);
        {bus.dp_in, bus.dm_in} = l;
        repeat (n) @(negedge clk);
    endtask
    task automatic sync_byte();
        put(K, 8); put(J, 8); put(K, 8); put(J, 8);
        put(K, 8); put(J, 8); put(K, 8); put(K, 8);
    endtask
    initial begin
        nmulti = 0;
        clr();
        rst = 1'b1;
        bus.dp_in = 1'b1; bus.dm_in = 1'b0; bus.rcv_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_shift_enable", bus.shift_enable, 0);
        chk("rst_serial_out", bus.serial_out, 0);
        chk("rst_eop", bus.eop, 0);
        chk("rst_stuff_err", bus.stuff_err, 0);
        chk("rst_active", bus.active, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.rcv_en = 1'b1;
        repeat (4) @(negedge clk);
        // sync, 0, six 1s, stuff bit, 1, EOP
        clr();
        edge_cyc = cyc;
        put(K, 1);
        chk("a_active_rise", bus.active, 1);
        put(K, 7); put(J, 8); put(K, 8); put(J, 8); put(K, 8); put(J, 8); put(K, 8); put(K, 8);
        chk("a_sync_count", nstb, 8);
        chk("a_sync_bits", bits & 32'hFF, 32'h01);
        chk("a_first_latency", first_cyc - edge_cyc, 4);
        chk("a_active_mid", bus.active, 1);
        put(J, 56); put(K, 8); put(K, 8); put(SE0, 16); put(J, 16);
        chk("a_count", nstb, 16);
        chk("a_bits", bits & 32'hFFFF, 32'h017F);
        chk("a_eop", neop, 1);
        chk("a_err", nerr, 0);
        chk("a_active_end", bus.active, 0);
        // seventh constant bit is a stuffing violation
        clr();
        sync_byte();
        put(J, 72);
        chk("b_count", nstb, 15);
        chk("b_bits", bits & 32'h7FFF, 32'h00BF);
        chk("b_err", nerr, 1);
        chk("b_err_active", err_active, 0);
        chk("b_eop", neop, 0);
        chk("b_active_end", bus.active, 0);
        // jittered bit lengths
        clr();
        put(K, 8); put(J, 9); put(K, 7); put(J, 8); put(K, 8); put(K, 8); put(SE0, 16); put(J, 16);
        chk("c_count", nstb, 6);
        chk("c_bits", bits & 32'h3F, 32'h01);
        chk("c_eop", neop, 1);
        chk("c_err", nerr, 0);
        // rcv_en dropped mid-bit, then a clean restart
        clr();
        put(K, 8); put(J, 8); put(K, 2);
        bus.rcv_en = 1'b0;
        @(negedge clk);
        chk("d_active_drop", bus.active, 0);
        put(K, 5); put(J, 8); put(SE0, 16); put(J, 16);
        chk("d_count", nstb, 2);
        chk("d_eop", neop, 0);
        chk("d_err", nerr, 0);
        bus.rcv_en = 1'b1;
        put(J, 4);
        clr();
        put(K, 8); put(J, 8); put(K, 8); put(K, 8); put(SE0, 16); put(J, 16);
        chk("d2_count", nstb, 4);
        chk("d2_bits", bits & 32'hF, 32'h1);
        chk("d2_eop", neop, 1);
        // asynchronous reset mid-packet, then a clean restart
        clr();
        put(K, 8); put(K, 10);
        chk("e_serial_before", bus.serial_out, 1);
        rst = 1'b1;
        {bus.dp_in, bus.dm_in} = J;
        #1;
        chk("e_rst_active", bus.active, 0);
        chk("e_rst_serial", bus.serial_out, 0);
        chk("e_rst_shift", bus.shift_enable, 0);
        @(negedge clk);
        rst = 1'b0;
        put(J, 4);
        chk("e_count", nstb, 2);
        chk("e_eop", neop, 0);
        clr();
        put(K, 8); put(J, 8); put(SE0, 16); put(J, 16);
        chk("e2_count", nstb, 2);
        chk("e2_bits", bits & 32'h3, 32'h0);
        chk("e2_eop", neop, 1);
        chk("e2_err", nerr, 0);
        chk("exclusive", nmulti, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
